// File: rtl/mc_ctrl_fsm.sv
// Multicycle control unit for the MIPS-subset datapath.
// Sequences fetch / decode / execute / memory / write-back. Fetch and both memory
// read phases are stretched to MEM_LAT+1 cycles. Invalid opcodes and arithmetic
// overflow divert to an exception sequence: save EPC, read the vector, load PC.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RESET_ST | held while reset=1; optionally writes stack-init into r29
// FETCH    | instruction read; IR and PC+4 written on the last cycle
// DECODE   | register read into A/B, branch target into ALUOut, dispatch
// EXEC_R   | R-type ALU operation (add/sub/and)
// WB_R     | write ALUOut to rd
// EXEC_I   | addi ALU operation
// WB_I     | write ALUOut to rt
// MEM_ADDR | effective address for lw/sw
// MEM_RD   | data read; MDR written on the last cycle
// WB_LW    | write MDR to rt
// MEM_WR   | single-cycle data write
// BRANCH   | beq/bne compare; PC <- ALUOut when taken
// JUMP     | PC <- jump target
// EXC_EPC  | EPC <- PC-4
// EXC_RD   | exception vector read; MDR written on the last cycle
// EXC_PC   | PC <- MDR
module mc_ctrl_fsm #(
    parameter int MEM_LAT       = 2,
    parameter bit STACK_INIT_EN = 1'b1,
    parameter bit EXC_EN        = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    input  logic       zero,
    output logic       pc_w,
    output logic       mem_w,
    output logic       ir_w,
    output logic       reg_w,
    output logic       a_w,
    output logic       b_w,
    output logic       aluout_w,
    output logic       mdr_w,
    output logic       epc_w,
    output logic [2:0] alu_op,
    output logic [1:0] iord_s,
    output logic       alusrca_s,
    output logic [1:0] alusrcb_s,
    output logic [1:0] pcsrc_s,
    output logic [1:0] regdst_s,
    output logic [1:0] memtoreg_s,
    output logic       exc_vec_s,
    output logic [4:0] state_o
);

    localparam int CW = ($clog2(MEM_LAT + 1) > 0) ? $clog2(MEM_LAT + 1) : 1;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;

    typedef enum logic [4:0] {
        RESET_ST = 5'd0,
        FETCH    = 5'd1,
        DECODE   = 5'd2,
        EXEC_R   = 5'd3,
        WB_R     = 5'd4,
        EXEC_I   = 5'd5,
        WB_I     = 5'd6,
        MEM_ADDR = 5'd7,
        MEM_RD   = 5'd8,
        WB_LW    = 5'd9,
        MEM_WR   = 5'd10,
        BRANCH   = 5'd11,
        JUMP     = 5'd12,
        EXC_EPC  = 5'd13,
        EXC_RD   = 5'd14,
        EXC_PC   = 5'd15
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          exc_vec_q, exc_vec_d;
    logic          cnt_last;
    logic          cnt_state;

    assign cnt_last  = (cnt_q == CW'(MEM_LAT));
    assign cnt_state = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == EXC_RD);
    assign state_o   = state_q;

    // State, wait counter and latched exception cause; synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RESET_ST;
            cnt_q     <= '0;
            exc_vec_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            exc_vec_q <= exc_vec_d;
        end
    end

    // Next-state decode and exception-cause capture
    always_comb begin
        state_d   = state_q;
        exc_vec_d = exc_vec_q;
        case (state_q)
            RESET_ST: state_d = FETCH;
            FETCH:    if (cnt_last) state_d = DECODE;
            DECODE: begin
                if (opcode == OP_R && (funct == F_ADD || funct == F_SUB || funct == F_AND))
                    state_d = EXEC_R;
                else if (opcode == OP_ADDI)
                    state_d = EXEC_I;
                else if (opcode == OP_LW || opcode == OP_SW)
                    state_d = MEM_ADDR;
                else if (opcode == OP_BEQ || opcode == OP_BNE)
                    state_d = BRANCH;
                else if (opcode == OP_J)
                    state_d = JUMP;
                else if (EXC_EN) begin
                    state_d   = EXC_EPC;
                    exc_vec_d = 1'b0;
                end else
                    state_d = FETCH;
            end
            EXEC_R: begin
                // and cannot overflow, so its overflow flag is ignored
                if (EXC_EN && overflow && funct != F_AND) begin
                    state_d   = EXC_EPC;
                    exc_vec_d = 1'b1;
                end else
                    state_d = WB_R;
            end
            EXEC_I: begin
                if (EXC_EN && overflow) begin
                    state_d   = EXC_EPC;
                    exc_vec_d = 1'b1;
                end else
                    state_d = WB_I;
            end
            WB_R, WB_I, WB_LW, MEM_WR, BRANCH, JUMP, EXC_PC: state_d = FETCH;
            MEM_ADDR: state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   if (cnt_last) state_d = WB_LW;
            EXC_EPC:  state_d = EXC_RD;
            EXC_RD:   if (cnt_last) state_d = EXC_PC;
            default:  state_d = RESET_ST;
        endcase
    end

    // Wait counter runs only while staying in a memory phase; zero on any entry
    always_comb begin
        cnt_d = '0;
        if (cnt_state && state_d == state_q)
            cnt_d = cnt_q + CW'(1);
    end

    // Moore output decode; pc_w in BRANCH additionally looks at zero
    always_comb begin
        pc_w       = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        a_w        = 1'b0;
        b_w        = 1'b0;
        aluout_w   = 1'b0;
        mdr_w      = 1'b0;
        epc_w      = 1'b0;
        alu_op     = 3'b000;
        iord_s     = 2'b00;
        alusrca_s  = 1'b0;
        alusrcb_s  = 2'b00;
        pcsrc_s    = 2'b00;
        regdst_s   = 2'b00;
        memtoreg_s = 2'b00;
        exc_vec_s  = 1'b0;
        case (state_q)
            RESET_ST: begin
                if (STACK_INIT_EN) begin
                    reg_w      = 1'b1;
                    regdst_s   = 2'b10;
                    memtoreg_s = 2'b10;
                end
            end
            FETCH: begin
                alusrcb_s = 2'b01;
                alu_op    = 3'b001;
                if (cnt_last) begin
                    ir_w = 1'b1;
                    pc_w = 1'b1;
                end
            end
            DECODE: begin
                a_w       = 1'b1;
                b_w       = 1'b1;
                alusrcb_s = 2'b11;
                alu_op    = 3'b001;
                aluout_w  = 1'b1;
            end
            EXEC_R: begin
                alusrca_s = 1'b1;
                aluout_w  = 1'b1;
                case (funct)
                    F_SUB:   alu_op = 3'b010;
                    F_AND:   alu_op = 3'b011;
                    default: alu_op = 3'b001;
                endcase
            end
            WB_R: begin
                reg_w    = 1'b1;
                regdst_s = 2'b01;
            end
            EXEC_I, MEM_ADDR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                alu_op    = 3'b001;
                aluout_w  = 1'b1;
            end
            WB_I: reg_w = 1'b1;
            MEM_RD: begin
                iord_s = 2'b01;
                mdr_w  = cnt_last;
            end
            WB_LW: begin
                reg_w      = 1'b1;
                memtoreg_s = 2'b01;
            end
            MEM_WR: begin
                iord_s = 2'b01;
                mem_w  = 1'b1;
            end
            BRANCH: begin
                alusrca_s = 1'b1;
                alu_op    = 3'b010;
                pcsrc_s   = 2'b01;
                pc_w      = (opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero);
            end
            JUMP: begin
                pc_w    = 1'b1;
                pcsrc_s = 2'b10;
            end
            EXC_EPC: begin
                alusrcb_s = 2'b01;
                alu_op    = 3'b010;
                epc_w     = 1'b1;
                exc_vec_s = exc_vec_q;
            end
            EXC_RD: begin
                iord_s    = 2'b10;
                mdr_w     = cnt_last;
                exc_vec_s = exc_vec_q;
            end
            EXC_PC: begin
                pc_w      = 1'b1;
                pcsrc_s   = 2'b11;
                exc_vec_s = exc_vec_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm with MEM_LAT=2, STACK_INIT_EN=1, EXC_EN=1.
module tb_mc_ctrl_fsm;

    localparam logic [4:0] S_RST = 5'd0,  S_FET = 5'd1,  S_DEC = 5'd2,  S_EXR = 5'd3;
    localparam logic [4:0] S_WBR = 5'd4,  S_EXI = 5'd5,  S_WBI = 5'd6,  S_MAD = 5'd7;
    localparam logic [4:0] S_MRD = 5'd8,  S_WBL = 5'd9,  S_MWR = 5'd10, S_BR  = 5'd11;
    localparam logic [4:0] S_J   = 5'd12, S_EEP = 5'd13, S_ERD = 5'd14, S_EPC = 5'd15;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       overflow, zero;
    logic       pc_w, mem_w, ir_w, reg_w, a_w, b_w, aluout_w, mdr_w, epc_w;
    logic [2:0] alu_op;
    logic [1:0] iord_s, alusrcb_s, pcsrc_s, regdst_s, memtoreg_s;
    logic       alusrca_s, exc_vec_s;
    logic [4:0] state_o;

    int total = 0;
    int bad   = 0;

    mc_ctrl_fsm #(.MEM_LAT(2), .STACK_INIT_EN(1'b1), .EXC_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .overflow(overflow), .zero(zero),
        .pc_w(pc_w), .mem_w(mem_w), .ir_w(ir_w), .reg_w(reg_w), .a_w(a_w), .b_w(b_w),
        .aluout_w(aluout_w), .mdr_w(mdr_w), .epc_w(epc_w), .alu_op(alu_op),
        .iord_s(iord_s), .alusrca_s(alusrca_s), .alusrcb_s(alusrcb_s),
        .pcsrc_s(pcsrc_s), .regdst_s(regdst_s), .memtoreg_s(memtoreg_s),
        .exc_vec_s(exc_vec_s), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Three fetch cycles with IR/PC written only on the last
    task automatic do_fetch(input string tag);
        tick(); chk({tag, " f1 state"}, 8'(state_o), 8'(S_FET)); chk({tag, " f1 ir_w"}, 8'(ir_w), 8'd0);
        chk({tag, " f1 alusrcb"}, 8'(alusrcb_s), 8'd1);
        tick(); chk({tag, " f2 state"}, 8'(state_o), 8'(S_FET)); chk({tag, " f2 ir_w"}, 8'(ir_w), 8'd0);
        tick(); chk({tag, " f3 state"}, 8'(state_o), 8'(S_FET)); chk({tag, " f3 ir_w"}, 8'(ir_w), 8'd1);
        chk({tag, " f3 pc_w"}, 8'(pc_w), 8'd1); chk({tag, " f3 pcsrc"}, 8'(pcsrc_s), 8'd0);
        tick(); chk({tag, " dec state"}, 8'(state_o), 8'(S_DEC));
        chk({tag, " dec a_w"}, 8'(a_w), 8'd1); chk({tag, " dec alusrcb"}, 8'(alusrcb_s), 8'd3);
        chk({tag, " dec aluout_w"}, 8'(aluout_w), 8'd1);
    endtask

    initial begin
        reset = 1'b1; opcode = 6'h00; funct = 6'h20; overflow = 1'b0; zero = 1'b0;

        // reset: stack init write
        tick(); chk("rst state", 8'(state_o), 8'(S_RST)); chk("rst reg_w", 8'(reg_w), 8'd1);
        chk("rst regdst", 8'(regdst_s), 8'd2); chk("rst memtoreg", 8'(memtoreg_s), 8'd2);
        chk("rst pc_w", 8'(pc_w), 8'd0);
        tick(); chk("rst2 state", 8'(state_o), 8'(S_RST));
        reset = 1'b0;

        // add, no overflow
        do_fetch("add");
        tick(); chk("add exr state", 8'(state_o), 8'(S_EXR)); chk("add alu_op", 8'(alu_op), 8'd1);
        chk("add alusrca", 8'(alusrca_s), 8'd1);
        tick(); chk("add wbr state", 8'(state_o), 8'(S_WBR)); chk("add reg_w", 8'(reg_w), 8'd1);
        chk("add regdst", 8'(regdst_s), 8'd1); chk("add memtoreg", 8'(memtoreg_s), 8'd0);

        // lw
        opcode = 6'h23;
        do_fetch("lw");
        tick(); chk("lw mad state", 8'(state_o), 8'(S_MAD)); chk("lw alusrcb", 8'(alusrcb_s), 8'd2);
        tick(); chk("lw rd1 state", 8'(state_o), 8'(S_MRD)); chk("lw rd1 iord", 8'(iord_s), 8'd1);
        chk("lw rd1 mdr_w", 8'(mdr_w), 8'd0);
        tick(); chk("lw rd2 state", 8'(state_o), 8'(S_MRD)); chk("lw rd2 mdr_w", 8'(mdr_w), 8'd0);
        tick(); chk("lw rd3 state", 8'(state_o), 8'(S_MRD)); chk("lw rd3 mdr_w", 8'(mdr_w), 8'd1);
        tick(); chk("lw wb state", 8'(state_o), 8'(S_WBL)); chk("lw memtoreg", 8'(memtoreg_s), 8'd1);
        chk("lw reg_w", 8'(reg_w), 8'd1); chk("lw regdst", 8'(regdst_s), 8'd0);

        // beq taken then not taken (zero is combinational)
        opcode = 6'h04; zero = 1'b1;
        do_fetch("beq");
        tick(); chk("beq state", 8'(state_o), 8'(S_BR)); chk("beq z1 pc_w", 8'(pc_w), 8'd1);
        chk("beq pcsrc", 8'(pcsrc_s), 8'd1); chk("beq alu_op", 8'(alu_op), 8'd2);
        zero = 1'b0; #1; chk("beq z0 pc_w", 8'(pc_w), 8'd0);

        // bne taken
        opcode = 6'h05;
        do_fetch("bne");
        tick(); chk("bne state", 8'(state_o), 8'(S_BR)); chk("bne z0 pc_w", 8'(pc_w), 8'd1);

        // sw
        opcode = 6'h2B;
        do_fetch("sw");
        tick(); chk("sw mad state", 8'(state_o), 8'(S_MAD));
        tick(); chk("sw state", 8'(state_o), 8'(S_MWR)); chk("sw mem_w", 8'(mem_w), 8'd1);
        chk("sw iord", 8'(iord_s), 8'd1);

        // j
        opcode = 6'h02;
        do_fetch("j");
        tick(); chk("j state", 8'(state_o), 8'(S_J)); chk("j pc_w", 8'(pc_w), 8'd1);
        chk("j pcsrc", 8'(pcsrc_s), 8'd2);

        // addi
        opcode = 6'h08; funct = 6'h3F;
        do_fetch("addi");
        tick(); chk("addi state", 8'(state_o), 8'(S_EXI)); chk("addi alusrcb", 8'(alusrcb_s), 8'd2);
        tick(); chk("addi wb state", 8'(state_o), 8'(S_WBI)); chk("addi reg_w", 8'(reg_w), 8'd1);
        chk("addi regdst", 8'(regdst_s), 8'd0);

        // invalid opcode exception
        opcode = 6'h3F;
        do_fetch("inv");
        tick(); chk("inv epc state", 8'(state_o), 8'(S_EEP)); chk("inv epc_w", 8'(epc_w), 8'd1);
        chk("inv exc_vec", 8'(exc_vec_s), 8'd0); chk("inv alu_op", 8'(alu_op), 8'd2);
        chk("inv alusrcb", 8'(alusrcb_s), 8'd1);
        tick(); chk("inv rd1 state", 8'(state_o), 8'(S_ERD)); chk("inv rd1 iord", 8'(iord_s), 8'd2);
        chk("inv rd1 mdr_w", 8'(mdr_w), 8'd0);
        tick(); chk("inv rd2 state", 8'(state_o), 8'(S_ERD));
        tick(); chk("inv rd3 state", 8'(state_o), 8'(S_ERD)); chk("inv rd3 mdr_w", 8'(mdr_w), 8'd1);
        tick(); chk("inv pc state", 8'(state_o), 8'(S_EPC)); chk("inv pc_w", 8'(pc_w), 8'd1);
        chk("inv pcsrc", 8'(pcsrc_s), 8'd3); chk("inv pc exc_vec", 8'(exc_vec_s), 8'd0);

        // add with overflow
        opcode = 6'h00; funct = 6'h20; overflow = 1'b1;
        do_fetch("ovf");
        tick(); chk("ovf exr state", 8'(state_o), 8'(S_EXR)); chk("ovf exr reg_w", 8'(reg_w), 8'd0);
        tick(); chk("ovf epc state", 8'(state_o), 8'(S_EEP)); chk("ovf exc_vec", 8'(exc_vec_s), 8'd1);
        chk("ovf epc reg_w", 8'(reg_w), 8'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("ovf rd state", 8'(state_o), 8'(S_ERD)); chk("ovf rd exc_vec", 8'(exc_vec_s), 8'd1);
            chk("ovf rd reg_w", 8'(reg_w), 8'd0);
        end
        tick(); chk("ovf pc state", 8'(state_o), 8'(S_EPC)); chk("ovf pc exc_vec", 8'(exc_vec_s), 8'd1);
        chk("ovf pc reg_w", 8'(reg_w), 8'd0);

        // and ignores overflow
        funct = 6'h24;
        do_fetch("and");
        tick(); chk("and alu_op", 8'(alu_op), 8'd3);
        tick(); chk("and wbr state", 8'(state_o), 8'(S_WBR));
        overflow = 1'b0;

        // reset in the middle of a memory read
        opcode = 6'h23;
        do_fetch("lwr");
        tick(); chk("lwr mad state", 8'(state_o), 8'(S_MAD));
        tick(); chk("lwr rd1 state", 8'(state_o), 8'(S_MRD));
        tick(); chk("lwr rd2 state", 8'(state_o), 8'(S_MRD));
        reset = 1'b1;
        tick(); chk("lwr rst state", 8'(state_o), 8'(S_RST)); chk("lwr rst mdr_w", 8'(mdr_w), 8'd0);
        reset = 1'b0;
        do_fetch("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
